// File: rtl/mips_multi_core.sv
// rtl/mips_multi_core.sv - multicycle MIPS core with control FSM and memory-mapped GPIO
module mips_multi_core #(
    parameter int          WIDTH     = 32,
    parameter int          GPIO_W    = 8,
    parameter logic [31:0] GPIO_ADDR = 32'h7FFC,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WIDTH-1:0]  mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic              mem_we,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [GPIO_W-1:0] gpio,
    output logic [3:0]        state_o,
    output logic              instr_done
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDIEX   = 4'd9;
    localparam logic [3:0] S_ADDIWB   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [3:0]       state;
    logic [3:0]       state_next;
    logic [WIDTH-1:0] pc;
    logic [31:0]      ir;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] rf [0:31];

    logic [5:0]       op;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             funct_ok;
    logic [WIDTH-1:0] alu_r;
    logic             is_gpio;
    logic [WIDTH-1:0] jump_pc;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    assign op       = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign imm_sext = WIDTH'($signed(ir[15:0]));
    assign rs_val   = (rs == 5'd0) ? '0 : rf[rs];
    assign rt_val   = (rt == 5'd0) ? '0 : rf[rt];
    assign is_gpio  = (alu_out == WIDTH'(GPIO_ADDR));
    // Jump keeps the upper PC bits above bit 27; narrower cores simply lose them.
    assign jump_pc  = (pc & ~WIDTH'(32'h0FFF_FFFF)) | WIDTH'({ir[25:0], 2'b00});

    assign state_o   = state;
    assign mem_wdata = b;
    assign mem_addr  = (state == S_MEMREAD || state == S_MEMWRITE) ? alu_out : pc;
    // A reset landing on the MEMWRITE cycle must not let the store through.
    assign mem_we    = (state == S_MEMWRITE) && !is_gpio && !reset;

    // R-type ALU; unknown funct yields 0 and is never written back.
    always_comb begin
        funct_ok = 1'b1;
        alu_r    = '0;
        case (funct)
            6'h20:   alu_r = a + b;
            6'h22:   alu_r = a - b;
            6'h24:   alu_r = a & b;
            6'h25:   alu_r = a | b;
            6'h2A:   alu_r = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            default: funct_ok = 1'b0;
        endcase
    end

    // Next-state sequencing and the end-of-instruction pulse.
    always_comb begin
        state_next = S_FETCH;
        instr_done = 1'b0;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      instr_done = 1'b1;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_next = S_MEMWB;
            S_EXEC:    state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP:
                instr_done = 1'b1;
            default:   state_next = S_FETCH;
        endcase
    end

    // Register-file write port selection by writeback state.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_out;
        case (state)
            S_MEMWB:  begin rf_we = 1'b1; rf_wdata = mdr; end
            S_ALUWB:  begin rf_we = funct_ok; rf_waddr = rd; end
            S_ADDIWB: rf_we = 1'b1;
            default:  rf_we = 1'b0;
        endcase
    end

    // Register file is not cleared by reset; $0 is never written.
    always_ff @(posedge clk) begin
        if (!reset && rf_we && rf_waddr != 5'd0)
            rf[rf_waddr] <= rf_wdata;
    end

    // Datapath registers, GPIO latch and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= WIDTH'(RESET_PC);
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            gpio    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH: begin
                    ir <= 32'(mem_rdata);
                    pc <= pc + WIDTH'(4);
                end
                S_DECODE: begin
                    a       <= rs_val;
                    b       <= rt_val;
                    alu_out <= pc + (imm_sext << 2);
                end
                S_MEMADR, S_ADDIEX: alu_out <= a + imm_sext;
                S_MEMREAD:          mdr <= mem_rdata;
                S_MEMWRITE:         if (is_gpio) gpio <= b[GPIO_W-1:0];
                S_EXEC:             alu_out <= alu_r;
                S_BRANCH:           if (a == b) pc <= alu_out;
                S_JUMP:             pc <= jump_pc;
                default: ;
            endcase
        end
    end
endmodule
